// File: rtl/issue_pkg.sv
// issue_pkg: shared states and constants for the instruction issuer and its ControlUnit decode.
package issue_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, LOAD, RUN} issue_state_e;
    localparam int IW_DEF = 16;
    localparam int RX_HI = 15;
    localparam int RX_LO = 13;
endpackage

// File: rtl/instr_issue_unit.sv
// instr_issue_unit: fetches instructions from a synchronous ROM and feeds them to the ControlUnit,
// prefetching one word so each retire is followed by a new instruction with no bubble.
module instr_issue_unit
    import issue_pkg::*;
#(
    parameter int IW = IW_DEF,
    parameter int AW = 8,
    parameter int PROG_LEN = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata,
    output logic [IW-1:0] instruction,
    output logic          run,
    input  logic          done,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          finished,
    output logic          aborted
);
    localparam int CW = $clog2(PROG_LEN + 1);

    issue_state_e  r_state, w_next;
    logic [CW-1:0] r_count;
    logic [IW-1:0] r_pf;
    logic          r_pf_valid;
    logic [1:0]    r_pf_pipe;
    logic          w_retire, w_last, w_stop;

    assign w_retire = r_state == RUN && run && done;
    assign w_last   = w_retire && r_count == CW'(PROG_LEN - 1);
    assign w_stop   = stop && r_state != IDLE;
    assign busy     = r_state != IDLE;

    always_comb begin
        w_next = (w_stop || w_last) ? IDLE :
                 r_state == IDLE    ? (start ? FETCH : IDLE) :
                 r_state == FETCH   ? LOAD : RUN;
    end

    // r_pf_pipe tracks the prefetch read: address issued, then ROM data captured two edges later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            instruction <= '0;
            pc          <= '0;
            imem_addr   <= '0;
            r_count     <= '0;
            r_pf        <= '0;
            r_pf_valid  <= 1'b0;
            r_pf_pipe   <= '0;
            run         <= 1'b0;
            finished    <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            r_state   <= w_next;
            finished  <= w_last;
            aborted   <= w_stop && !w_last;
            r_pf_pipe <= {r_pf_pipe[0], 1'b0};
            if (r_pf_pipe[1]) begin
                r_pf       <= imem_rdata;
                r_pf_valid <= 1'b1;
            end
            if (r_state == IDLE && start) begin
                pc         <= '0;
                imem_addr  <= '0;
                r_count    <= '0;
                r_pf_valid <= 1'b0;
                r_pf_pipe  <= '0;
            end
            if (r_state == LOAD && !w_stop) begin
                instruction <= imem_rdata;
                run         <= 1'b1;
                imem_addr   <= pc + AW'(1);
                r_pf_pipe   <= 2'b01;
            end
            if (w_retire)
                r_count <= r_count + 1'b1;
            if (w_retire && !w_last && !w_stop) begin
                instruction <= r_pf;
                pc          <= pc + AW'(1);
                imem_addr   <= pc + AW'(2);
                r_pf_valid  <= 1'b0;
                r_pf_pipe   <= 2'b01;
            end
            if (w_stop || w_last)
                run <= 1'b0;
        end
    end

    // a retire before the prefetch lands means the ControlUnit broke its minimum 3-cycle spacing
    assert property (@(posedge clk) disable iff (reset) w_retire |-> r_pf_valid);

endmodule

// File: tb/tb_instr_issue_unit.sv
// tb_instr_issue_unit: scoreboard bench pairing the issuer with a ROM model and a 3-cycle ControlUnit model.
module tb_instr_issue_unit;
    import issue_pkg::*;
    localparam int IW = 16;
    typedef struct packed {
        logic [7:0]    pc;
        logic [IW-1:0] ins;
    } ret_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    int n_pass = 0;
    int n_total = 0;

    logic          a_start = 1'b0, a_stop = 1'b0, a_run, a_done, a_busy, a_fin, a_abt;
    logic [7:0]    a_addr, a_pc;
    logic [IW-1:0] a_rdata = '0, a_ins;
    logic [IW-1:0] rom_a [256];
    logic [1:0]    a_cnt = '0;

    logic          b_start = 1'b0, b_stop = 1'b0, b_run, b_done, b_busy, b_fin, b_abt;
    logic [1:0]    b_addr, b_pc;
    logic [IW-1:0] b_rdata = '0, b_ins;
    logic [IW-1:0] rom_b [4];
    logic [1:0]    b_cnt = '0;

    logic [IW-1:0] prog [4];
    ret_t          qa[$], qb[$];
    logic [1:0]    qea[$], qeb[$];

    instr_issue_unit #(.IW(IW), .AW(8), .PROG_LEN(4)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .stop(a_stop), .imem_addr(a_addr),
        .imem_rdata(a_rdata), .instruction(a_ins), .run(a_run), .done(a_done), .pc(a_pc),
        .busy(a_busy), .finished(a_fin), .aborted(a_abt));

    instr_issue_unit #(.IW(IW), .AW(2), .PROG_LEN(6)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .stop(b_stop), .imem_addr(b_addr),
        .imem_rdata(b_rdata), .instruction(b_ins), .run(b_run), .done(b_done), .pc(b_pc),
        .busy(b_busy), .finished(b_fin), .aborted(b_abt));

    // ROMs register the address; ControlUnit model retires 3 cycles after each run rise / IR change
    always @(posedge clk) begin
        a_rdata <= rom_a[a_addr];
        b_rdata <= rom_b[b_addr];
        a_cnt   <= (!a_run || a_done) ? 2'd0 : a_cnt + 2'd1;
        b_cnt   <= (!b_run || b_done) ? 2'd0 : b_cnt + 2'd1;
    end
    assign a_done = a_run && a_cnt == 2'd2;
    assign b_done = b_run && b_cnt == 2'd2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    ret_t          ea, eb;
    logic [1:0]    eva, evb;
    logic          a_prun = 1'b0, a_pret = 1'b0;
    logic [IW-1:0] a_pins = '0;

    always @(negedge clk) begin
        if (!reset) begin
            if (a_run && a_done) begin
                chk("a_retire_expected", qa.size() != 0, 1);
                if (qa.size() != 0) begin
                    ea = qa.pop_front();
                    chk("a_retire_pc", a_pc, ea.pc);
                    chk("a_retire_ins", a_ins, ea.ins);
                    chk("a_retire_rx", a_ins[RX_HI:RX_LO], ea.ins[RX_HI:RX_LO]);
                end
            end
            if (a_fin || a_abt) begin
                chk("a_event_expected", qea.size() != 0, 1);
                if (qea.size() != 0) begin
                    eva = qea.pop_front();
                    chk("a_event_kind", {a_fin, a_abt}, eva);
                end
            end
            if (a_prun && !a_run) chk("a_run_drop_cause", a_fin | a_abt, 1);
            if (a_pret && a_run) chk("a_ir_changed_after_done", a_ins != a_pins, 1);
        end
        a_prun = a_run;
        a_pret = a_run && a_done;
        a_pins = a_ins;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (b_run && b_done) begin
                chk("b_retire_expected", qb.size() != 0, 1);
                if (qb.size() != 0) begin
                    eb = qb.pop_front();
                    chk("b_retire_pc", b_pc, eb.pc);
                    chk("b_retire_ins", b_ins, eb.ins);
                end
            end
            if (b_fin || b_abt) begin
                chk("b_event_expected", qeb.size() != 0, 1);
                if (qeb.size() != 0) begin
                    evb = qeb.pop_front();
                    chk("b_event_kind", {b_fin, b_abt}, evb);
                end
            end
        end
    end

    task automatic pulse_a(input logic st, input logic sp);
        a_start = st;
        a_stop  = sp;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_stop  = 1'b0;
    endtask

    task automatic push_a(input int n, input logic [1:0] ev);
        for (int i = 0; i < n; i++) qa.push_back('{pc: 8'(i), ins: prog[i]});
        qea.push_back(ev);
    endtask

    task automatic wait_done_a(input int k);
        int n = 0, seen = 0;
        while (seen < k && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (a_done) seen++;
        end
        chk("a_done_reached", seen, k);
    endtask

    task automatic wait_idle_a(input string name);
        int n = 0;
        while (a_busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, a_busy, 0);
    endtask

    initial begin
        prog = '{16'h2000, 16'h4000, 16'h6000, 16'h8000};
        for (int i = 0; i < 256; i++) rom_a[i] = 16'h1e00 + 16'(i);
        for (int i = 0; i < 4; i++) begin
            rom_a[i] = prog[i];
            rom_b[i] = prog[i];
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_run", a_run, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_pc", a_pc, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_ins", a_ins, 0);
        chk("rst_pulses", {a_fin, a_abt}, 0);
        reset = 1'b0;

        // full program, back to back
        push_a(4, 2'b10);
        pulse_a(1'b1, 1'b0);
        @(negedge clk);
        chk("run_c1", a_run, 0);
        chk("busy_c1", a_busy, 1);
        @(negedge clk);
        chk("run_c2", a_run, 0);
        @(negedge clk);
        chk("run_c3", a_run, 1);
        chk("ins_c3", a_ins, 16'h2000);
        chk("pc_c3", a_pc, 0);
        wait_idle_a("full_idle");
        chk("full_run_low", a_run, 0);
        chk("full_ins_hold", a_ins, 16'h8000);
        chk("full_pc_hold", a_pc, 3);
        chk("full_count", u_a.r_count, 4);

        // stop two cycles after the second IR load
        qa.push_back('{pc: 8'd0, ins: 16'h2000});
        qea.push_back(2'b01);
        pulse_a(1'b1, 1'b0);
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("stop_ins_before", a_ins, 16'h4000);
        pulse_a(1'b0, 1'b1);
        chk("stop_aborted", a_abt, 1);
        chk("stop_finished", a_fin, 0);
        chk("stop_run", a_run, 0);
        chk("stop_pc", a_pc, 1);
        chk("stop_count", u_a.r_count, 1);

        // stop together with the last done: finish wins
        push_a(4, 2'b10);
        pulse_a(1'b1, 1'b0);
        wait_done_a(4);
        pulse_a(1'b0, 1'b1);
        chk("stoplast_fin", a_fin, 1);
        chk("stoplast_abt", a_abt, 0);
        chk("stoplast_count", u_a.r_count, 4);

        // stop together with a non-last done: retire then abort
        push_a(1, 2'b01);
        pulse_a(1'b1, 1'b0);
        wait_done_a(1);
        pulse_a(1'b0, 1'b1);
        chk("stopmid_abt", a_abt, 1);
        chk("stopmid_fin", a_fin, 0);
        chk("stopmid_count", u_a.r_count, 1);
        chk("stopmid_pc", a_pc, 0);

        // start+stop in IDLE starts; start while busy ignored
        push_a(4, 2'b10);
        pulse_a(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("startstop_run", a_run, 1);
        wait_done_a(1);
        pulse_a(1'b1, 1'b0);
        wait_idle_a("busystart_idle");
        chk("busystart_count", u_a.r_count, 4);
        chk("busystart_pc", a_pc, 3);

        // asynchronous reset mid-run
        pulse_a(1'b1, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("prereset_run", a_run, 1);
        #2 reset = 1'b1;
        #1;
        chk("areset_run", a_run, 0);
        chk("areset_busy", a_busy, 0);
        chk("areset_pc", a_pc, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        // AW=2, PROG_LEN=6: pc wraps and ROM[0] is the 5th instruction
        for (int i = 0; i < 6; i++) qb.push_back('{pc: 8'(i % 4), ins: prog[i % 4]});
        qeb.push_back(2'b10);
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (int n = 0; n < 100 && b_busy; n++) begin
            @(posedge clk); #1;
        end
        chk("wrap_idle", b_busy, 0);
        chk("wrap_pc", b_pc, 1);
        chk("wrap_ins", b_ins, 16'h4000);

        repeat (3) @(posedge clk);
        #1;
        chk("qa_drained", qa.size(), 0);
        chk("qea_drained", qea.size(), 0);
        chk("qb_drained", qb.size(), 0);
        chk("qeb_drained", qeb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
